tlc_timer: RTL and testbench

- Countdown datapath for the traffic-light controller: the responder side of the dp_rst / dp_value / cnt_done interface.
- The controller pulses dp_rst with a duration in seconds. This block counts that duration down using a seconds prescaler, then raises cnt_done.
- It also exports the remaining time, in binary and as BCD, for a pedestrian countdown display.

---
 rtl/tlc_pkg.sv | 17 +
 rtl/tlc_bin2bcd.sv | 28 ++
 rtl/tlc_timer.sv | 82 ++++++++
 tb/tb_tlc_timer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared constants and state type for the traffic-light controller
package tlc_pkg;

  localparam int VAL_W        = 5;
  localparam int T_RED        = 28;
  localparam int T_YELLOW     = 3;
  localparam int T_GREEN      = 28;
  localparam int TICK_DIV_DEF = 50000000;
  localparam int TICK_DIV_SIM = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tlc_state_e;

endpackage

// File: rtl/tlc_bin2bcd.sv
// rtl/tlc_bin2bcd.sv - combinational binary to two-digit BCD by repeated compare-subtract
module tlc_bin2bcd #(
  parameter int VAL_W = tlc_pkg::VAL_W
) (
  input  logic [VAL_W-1:0] value,
  output logic [3:0]       tens,
  output logic [3:0]       ones
);

  localparam int MAX_TENS = ((1 << VAL_W) - 1) / 10;

  logic [VAL_W-1:0] rem;
  logic [3:0]       tens_cnt;

  always_comb begin
    rem      = value;
    tens_cnt = 4'd0;
    for (int i = 0; i < MAX_TENS; i++) begin
      if (rem >= VAL_W'(10)) begin
        rem      = rem - VAL_W'(10);
        tens_cnt = tens_cnt + 4'd1;
      end
    end
    tens = tens_cnt;
    ones = rem[3:0];
  end

endmodule

// File: rtl/tlc_timer.sv
// rtl/tlc_timer.sv - seconds countdown responding to dp_rst/dp_value with cnt_done and BCD readout
module tlc_timer #(
  parameter int TICK_DIV = tlc_pkg::TICK_DIV_DEF,
  parameter int VAL_W    = tlc_pkg::VAL_W,
  parameter int PRE_W    = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dp_rst,
  input  logic [VAL_W-1:0] dp_value,
  input  logic             pause,
  output logic             cnt_done,
  output logic             tick,
  output logic [VAL_W-1:0] remaining,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic             busy
);

  import tlc_pkg::*;

  tlc_state_e       state, state_nxt;
  logic [PRE_W-1:0] pre;
  logic             sec_end;
  logic             run_en;
  logic [3:0]       tens_c, ones_c;

  assign sec_end = (pre == PRE_W'(TICK_DIV - 1));
  assign run_en  = (state == ST_RUN) && !pause;

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // ST_RUN always implies remaining > 0, so the last tick is remaining==1 at sec_end
  always_comb begin
    state_nxt = state;
    if (dp_rst)
      state_nxt = (dp_value == '0) ? ST_DONE : ST_RUN;
    else if (run_en && sec_end && remaining == VAL_W'(1))
      state_nxt = ST_DONE;
  end

  always_comb begin
    cnt_done = (state == ST_DONE);
    busy     = (state == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre       <= '0;
      remaining <= '0;
      tick      <= 1'b0;
      bcd_tens  <= 4'd0;
      bcd_ones  <= 4'd0;
    end else begin
      tick     <= 1'b0;
      bcd_tens <= tens_c;
      bcd_ones <= ones_c;
      if (dp_rst) begin
        remaining <= dp_value;
        pre       <= '0;
      end else if (run_en) begin
        if (sec_end) begin
          pre       <= '0;
          remaining <= remaining - VAL_W'(1);
          tick      <= 1'b1;
        end else begin
          pre <= pre + PRE_W'(1);
        end
      end
    end
  end

  tlc_bin2bcd #(.VAL_W(VAL_W)) u_bin2bcd (
    .value (remaining),
    .tens  (tens_c),
    .ones  (ones_c)
  );

endmodule

// File: tb/tb_tlc_timer.sv
// tb/tb_tlc_timer.sv - directed self-checking bench for tlc_timer with a tick scoreboard
module tb_tlc_timer;

  localparam int TD = tlc_pkg::TICK_DIV_SIM;

  logic       clk;
  logic       rst;
  logic       dp_rst;
  logic [4:0] dp_value;
  logic       pause;
  logic       cnt_done;
  logic       tick;
  logic [4:0] remaining;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       busy;

  int n_pass;
  int n_total;
  int exp_q[$];
  int c;

  tlc_timer #(.TICK_DIV(TD), .VAL_W(5), .PRE_W(26)) dut (
    .clk       (clk),
    .rst       (rst),
    .dp_rst    (dp_rst),
    .dp_value  (dp_value),
    .pause     (pause),
    .cnt_done  (cnt_done),
    .tick      (tick),
    .remaining (remaining),
    .bcd_tens  (bcd_tens),
    .bcd_ones  (bcd_ones),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // one clock edge, then sample 1ns later; each observed tick pops the scoreboard
  task automatic cyc();
    @(posedge clk);
    #1;
    if (tick) begin
      if (exp_q.size() == 0) check("tick_unexpected", int'(tick), 0);
      else check("tick_remaining", int'(remaining), exp_q.pop_front());
    end
  endtask

  task automatic load_edge(input int v);
    exp_q.delete();
    for (int k = v - 1; k >= 0; k--) exp_q.push_back(k);
    dp_rst   = 1'b1;
    dp_value = 5'(v);
    cyc();
    dp_rst   = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!cnt_done && n < budget) begin
      cyc();
      n++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_done"}, int'(cnt_done), 0);
    check({tag, "_tick"}, int'(tick), 0);
    check({tag, "_rem"}, int'(remaining), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_tens"}, int'(bcd_tens), 0);
    check({tag, "_ones"}, int'(bcd_ones), 0);
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    rst      = 1'b0;
    dp_rst   = 1'b0;
    dp_value = 5'd0;
    pause    = 1'b0;

    // reset, then idle with no load
    cyc();
    cyc();
    check_all_zero("reset");
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("idle_done", int'(cnt_done), 0);
      check("idle_rem", int'(remaining), 0);
      check("idle_busy", int'(busy), 0);
    end

    // load 3 and follow it down
    load_edge(3);
    check("l3_busy", int'(busy), 1);
    check("l3_rem", int'(remaining), 3);
    check("l3_done", int'(cnt_done), 0);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      check("l3_rem_k", int'(remaining), 3 - k / TD);
      check("l3_ones_lag", int'(bcd_ones), 3 - (k - 1) / TD);
      check("l3_done_k", int'(cnt_done), (k >= 12) ? 1 : 0);
    end
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("l3_hold_done", int'(cnt_done), 1);
      check("l3_hold_busy", int'(busy), 0);
    end
    check("l3_queue_empty", exp_q.size(), 0);

    // load 0 completes at the load edge
    load_edge(0);
    check("l0_done", int'(cnt_done), 1);
    check("l0_busy", int'(busy), 0);
    check("l0_rem", int'(remaining), 0);
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("l0_hold", int'(cnt_done), 1);
    end

    // load 28 with a 10-cycle pause after two prescaler counts
    load_edge(28);
    c = 0;
    check("l28_done_drop", int'(cnt_done), 0);
    check("l28_rem", int'(remaining), 28);
    cyc(); c++;
    check("l28_bcd_tens", int'(bcd_tens), 2);
    check("l28_bcd_ones", int'(bcd_ones), 8);
    cyc(); c++;
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(); c++;
      check("l28_pause_rem", int'(remaining), 28);
      check("l28_pause_busy", int'(busy), 1);
    end
    pause = 1'b0;
    wait_done(300, c);
    check("l28_done_edge", c + 12, 28 * TD + 10);
    check("l28_queue_empty", exp_q.size(), 0);

    // reload mid-count with pause asserted on the reload edge
    load_edge(5);
    for (int i = 0; i < 6; i++) cyc();
    pause = 1'b1;
    load_edge(2);
    pause = 1'b0;
    check("reload_rem", int'(remaining), 2);
    check("reload_done", int'(cnt_done), 0);
    check("reload_busy", int'(busy), 1);
    wait_done(100, c);
    check("reload_done_edge", c, 2 * TD);

    // dp_rst held high for three edges: countdown starts after the last one
    load_edge(1);
    load_edge(1);
    load_edge(1);
    check("hold_rem", int'(remaining), 1);
    wait_done(100, c);
    check("hold_done_edge", c, TD);

    // reset mid-countdown abandons the count
    load_edge(3);
    for (int i = 0; i < TD; i++) cyc();
    check("mid_rem", int'(remaining), 2);
    rst = 1'b0;
    exp_q.delete();
    cyc();
    check_all_zero("midrst");
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      cyc();
      check("post_rst_done", int'(cnt_done), 0);
      check("post_rst_rem", int'(remaining), 0);
    end

    // done-state load must drop cnt_done at the load edge
    load_edge(0);
    check("pre_done", int'(cnt_done), 1);
    load_edge(3);
    check("done_drop", int'(cnt_done), 0);
    check("done_drop_busy", int'(busy), 1);
    wait_done(100, c);
    check("final_done_edge", c, 3 * TD);
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
